key_expand_seq: RTL and testbench

//   Word-serial AES-128 key expansion. Latches a 128-bit cipher key and produces round keys 0..NR in order.

---
 rtl/aes_pkg.sv | 20 ++
 rtl/aes_sbox.sv | 31 +++
 rtl/key_expand_seq.sv | 126 ++++++++++++
 tb/tb_key_expand_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, key-schedule state encoding and GF(2^8) helpers.
package aes_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    COMPUTE,
    FINISH
  } kx_state_t;

  localparam byte_t RCON_INIT = 8'h01;

  function automatic byte_t xtime(input byte_t r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, 256-entry lookup.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] idx;

  assign idx = 11'd2047 - {a_i, 3'b000};
  assign s_o = SBOX[idx -: 8];

endmodule

// File: rtl/key_expand_seq.sv
// Word-serial AES-128 key expansion; one schedule word per clock,
// round keys handed out over a valid/ready port.
module key_expand_seq #(
  parameter int NR      = 10,
  parameter bit EMIT_R0 = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_data,
  output logic         done
);
  import aes_pkg::*;

  if (NR != 10) begin : g_nr_chk
    $error("key_expand_seq: only NR=10 is supported");
  end

  localparam logic [3:0] LAST = 4'(NR);

  kx_state_t    state_q, state_d;
  word_t        w_q [4];
  word_t        w_d [4];
  logic [1:0]   wcnt_q, wcnt_d;
  byte_t        rcon_q, rcon_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] rkd_q, rkd_d;

  byte_t sb [4];
  word_t subrot;
  word_t mix;

  // RotWord folded into the S-box taps: byte g reads w3 byte (g+1)%4
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i (w_q[3][31-8*((g+1)%4) -: 8]),
      .s_o (sb[g])
    );
  end

  assign subrot = {sb[0] ^ rcon_q, sb[1], sb[2], sb[3]};

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    wcnt_d  = wcnt_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    rkd_d   = rkd_q;
    mix     = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          w_d[0]  = key_in[127:96];
          w_d[1]  = key_in[95:64];
          w_d[2]  = key_in[63:32];
          w_d[3]  = key_in[31:0];
          round_d = '0;
          rcon_d  = RCON_INIT;
          wcnt_d  = '0;
          if (EMIT_R0) begin
            state_d = PRESENT;
            rkd_d   = key_in;
          end else begin
            state_d = COMPUTE;
          end
        end
      end
      PRESENT: begin
        if (rk_ready) begin
          if (round_q == LAST) begin
            state_d = FINISH;
          end else begin
            state_d = COMPUTE;
            wcnt_d  = '0;
          end
        end
      end
      COMPUTE: begin
        mix = (wcnt_q == 2'd0) ? subrot
                               : w_q[wcnt_q - 2'd1];
        w_d[wcnt_q] = w_q[wcnt_q] ^ mix;
        wcnt_d      = wcnt_q + 2'd1;
        if (wcnt_q == 2'd3) begin
          round_d = round_q + 4'd1;
          rcon_d  = xtime(rcon_q);
          state_d = PRESENT;
          rkd_d   = {w_d[0], w_d[1], w_d[2], w_d[3]};
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '{default: '0};
      wcnt_q  <= '0;
      rcon_q  <= RCON_INIT;
      round_q <= '0;
      rkd_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      wcnt_q  <= wcnt_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
      rkd_q   <= rkd_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign rk_valid = (state_q == PRESENT);
  assign rk_round = round_q;
  assign rk_data  = rkd_q;
  assign done     = (state_q == FINISH);

endmodule

// File: tb/tb_key_expand_seq.sv
// Directed bench for key_expand_seq: software key schedule feeds a
// scoreboard that is drained as round keys are handed out.
module tb_key_expand_seq;

  logic         clk = 1'b0;
  logic         rst, start_a, start_b, rk_ready;
  logic [127:0] key_in;

  logic         busy_a, valid_a, done_a;
  logic [3:0]   round_a;
  logic [127:0] data_a;
  logic         busy_b, valid_b, done_b;
  logic [3:0]   round_b;
  logic [127:0] data_b;

  always #5 clk = ~clk;

  key_expand_seq #(.NR(10), .EMIT_R0(1'b1)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .start    (start_a),
    .key_in   (key_in),
    .busy     (busy_a),
    .rk_valid (valid_a),
    .rk_ready (rk_ready),
    .rk_round (round_a),
    .rk_data  (data_a),
    .done     (done_a)
  );

  key_expand_seq #(.NR(10), .EMIT_R0(1'b0)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .start    (start_b),
    .key_in   (key_in),
    .busy     (busy_b),
    .rk_valid (valid_b),
    .rk_ready (rk_ready),
    .rk_round (round_b),
    .rk_data  (data_b),
    .done     (done_b)
  );

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] data;
  } exp_t;

  exp_t         sbq [$];
  logic [7:0]   sbx [256];
  logic [127:0] rk  [11];
  logic [127:0] got [11];
  int           nvec = 0;
  int           nerr = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box from first principles: GF inverse then affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbx[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3)
             ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbx[t[31:24]] ^ rc, sbx[t[23:16]], sbx[t[15:8]], sbx[t[7:0]]};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit which_b, input logic v);
    if (which_b) start_b = v;
    else start_a = v;
  endtask

  task automatic run(input bit which_b, input logic [127:0] key, input int stall,
                     input int glitch, input logic [127:0] gkey,
                     input int abort_rnd, input int exp_done);
    logic         v, dn, b, seen;
    logic [3:0]   r;
    logic [127:0] d;
    int           cyc, ndone, ntx, dcyc;
    bit           fin, ab;
    cyc = 0; ndone = 0; ntx = 0; dcyc = -1; fin = 0; ab = 0;
    expand(key);
    sbq.delete();
    for (int i = (which_b ? 1 : 0); i <= 10; i++)
      sbq.push_back('{rnd: 4'(i), data: rk[i]});
    for (int i = 0; i < 11; i++) got[i] = '0;
    @(negedge clk);
    key_in = key;
    set_start(which_b, 1'b1);
    @(posedge clk); #1;
    set_start(which_b, 1'b0);
    while (!fin && cyc < 400) begin
      v  = which_b ? valid_b : valid_a;
      dn = which_b ? done_b  : done_a;
      r  = which_b ? round_b : round_a;
      d  = which_b ? data_b  : data_a;
      rk_ready = 1'($urandom_range(0, 1));
      if (dn) begin
        ndone++;
        dcyc = cyc;
        fin  = 1;
      end
      if (v) begin
        if (sbq.size() == 0) begin
          nvec++;
          nerr++;
          $error("FAIL extra_key observed round=%0d expected none", r);
        end else begin
          chk("rk_round", {124'd0, r}, {124'd0, sbq[0].rnd});
          chk("rk_data", d, sbq[0].data);
          if (abort_rnd == int'(r)) begin
            rst = 1'b1;
            ab  = 1;
            fin = 1;
          end else begin
            rk_ready = ($urandom_range(0, 99) >= stall);
            if (rk_ready) begin
              got[r] = d;
              void'(sbq.pop_front());
              ntx++;
            end
          end
        end
      end
      if (cyc == glitch) begin
        key_in = gkey;
        set_start(which_b, 1'b1);
      end else begin
        set_start(which_b, 1'b0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    set_start(which_b, 1'b0);
    if (ab) begin
      rst = 1'b0;
      chk("abort_busy", 128'(busy_a), 128'd0);
      chk("abort_valid", 128'(valid_a), 128'd0);
      chk("abort_done", 128'(done_a), 128'd0);
      chk("abort_round", 128'(round_a), 128'd0);
      chk("abort_data", data_a, 128'd0);
      seen = 1'b0;
      repeat (8) begin
        @(posedge clk); #1;
        seen = seen | done_a;
      end
      chk("abort_no_done", 128'(seen), 128'd0);
      sbq.delete();
    end else begin
      b = which_b ? busy_b : busy_a;
      chk("timeout", 128'(fin), 128'd1);
      chk("done_cnt", 128'(ndone), 128'd1);
      chk("tx_cnt", 128'(ntx), which_b ? 128'd10 : 128'd11);
      chk("sb_empty", 128'(sbq.size()), 128'd0);
      chk("idle_after", 128'(b), 128'd0);
      chk("done_pulse", 128'(which_b ? done_b : done_a), 128'd0);
      if (exp_done >= 0) chk("done_cyc", 128'(dcyc), 128'(exp_done));
    end
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    rk_ready = 1'b0; key_in = '0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy_a), 128'd0);
    chk("rst_valid", 128'(valid_a), 128'd0);
    chk("rst_round", 128'(round_a), 128'd0);
    chk("rst_data", data_a, 128'd0);
    chk("rst_done", 128'(done_a), 128'd0);
    chk("rst_valid_b", 128'(valid_b), 128'd0);
    rst = 1'b0;

    run(1'b0, FIPS_KEY, 0, -1, '0, -1, 51);
    chk("fips_r0", got[0], FIPS_KEY);
    chk("fips_r1", got[1], FIPS_R1);
    chk("fips_r10", got[10], FIPS_R10);

    run(1'b0, 128'd0, 30, -1, '0, -1, -1);
    chk("zero_r1", got[1], ZERO_R1);
    chk("zero_r10", got[10], ZERO_R10);

    run(1'b0, {$urandom, $urandom, $urandom, $urandom}, 0, 2,
        128'hdeadbeef_01234567_89abcdef_0f1e2d3c, -1, 51);

    run(1'b0, FIPS_KEY, 30, -1, '0, 5, -1);

    run(1'b0, FIPS_KEY, 30, -1, '0, -1, -1);
    chk("rerun_r10", got[10], FIPS_R10);

    run(1'b1, FIPS_KEY, 0, -1, '0, -1, 50);
    chk("nor0_r1", got[1], FIPS_R1);
    chk("nor0_r10", got[10], FIPS_R10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
